// File: rtl/walking_one_rr_arbiter.sv
// Round-robin arbiter with a walking-one priority pointer, one-hot grant,
// registered data mux and an optional maximum-hold limit that forces rotation.
module walking_one_rr_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Enable,
    input  logic [NUM_CH-1:0]              Request,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   DataIn,
    output logic [NUM_CH-1:0]              Grant,
    output logic [$clog2(NUM_CH)-1:0]      GrantIndex,
    output logic                           GrantValid,
    output logic [DATA_WIDTH-1:0]          DataOut,
    output logic                           HoldExpired
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [NUM_CH-1:0]       grant;
    logic [NUM_CH-1:0]       next_grant;
    logic [NUM_CH-1:0]       ptr;
    logic [NUM_CH-1:0]       next_ptr;
    logic [NUM_CH-1:0]       rot_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        next_count;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH-1:0]   next_data;
    logic                    hold_expired;
    logic                    next_expired;
    logic                    cur_req;
    logic                    at_limit;

    // First requester at or above the one-hot start bit, wrapping circularly.
    function automatic logic [NUM_CH-1:0] pick(input logic [NUM_CH-1:0] req,
                                               input logic [NUM_CH-1:0] start);
        logic [NUM_CH-1:0] res;
        logic              found;
        res   = '0;
        found = 1'b0;
        for (int s = 0; s < NUM_CH; s++) begin
            if (start[s]) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!found && req[(s + k) % NUM_CH]) begin
                        res[(s + k) % NUM_CH] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [NUM_CH-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (onehot[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    assign rot_ptr  = {grant[NUM_CH-2:0], grant[NUM_CH-1]};
    assign cur_req  = |(Request & grant);
    assign at_limit = (MAX_HOLD != 0) && (count == CNT_W'(MAX_HOLD));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state        <= IDLE;
            grant        <= '0;
            ptr          <= NUM_CH'(1);
            count        <= '0;
            data         <= '0;
            hold_expired <= 1'b0;
        end else if (Enable) begin
            state        <= next_state;
            grant        <= next_grant;
            ptr          <= next_ptr;
            count        <= next_count;
            data         <= next_data;
            hold_expired <= next_expired;
        end else begin
            hold_expired <= 1'b0;
        end
    end

    // Release and expiry both hand over in the same cycle using the rotated pointer.
    always_comb begin
        next_state   = state;
        next_grant   = grant;
        next_ptr     = ptr;
        next_count   = count;
        next_expired = 1'b0;
        case (state)
            IDLE: begin
                next_count = '0;
                if (|Request) begin
                    next_grant = pick(Request, ptr);
                    next_state = GRANTED;
                    next_count = CNT_W'(1);
                end
            end
            GRANTED: begin
                if (cur_req && !at_limit) begin
                    if (count != {CNT_W{1'b1}}) next_count = count + 1'b1;
                end else begin
                    next_ptr     = rot_ptr;
                    next_expired = cur_req;
                    next_grant   = pick(Request, rot_ptr);
                    if (|Request) begin
                        next_state = GRANTED;
                        next_count = CNT_W'(1);
                    end else begin
                        next_state = IDLE;
                        next_count = '0;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_grant = '0;
            end
        endcase
    end

    always_comb begin
        next_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (next_grant[i]) next_data = DataIn[i*DATA_WIDTH +: DATA_WIDTH];
        end
        GrantValid  = (state == GRANTED);
        GrantIndex  = encode(grant);
        Grant       = grant;
        DataOut     = data;
        HoldExpired = hold_expired;
    end

endmodule

// File: tb/tb_walking_one_rr_arbiter.sv
// Directed bench for walking_one_rr_arbiter: three instances cover unlimited,
// MAX_HOLD=3 and MAX_HOLD=2 configurations sharing clock, reset, enable and data.
module tb_walking_one_rr_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [3:0]  req0, req2, req3;
    logic [31:0] din [4];
    logic [127:0] data_in;

    logic [3:0]  g0, g2, g3;
    logic [1:0]  gi0, gi2, gi3;
    logic        gv0, gv2, gv3;
    logic [31:0] do0, do2, do3;
    logic        he0, he2, he3;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    always_comb begin
        for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = din[i];
    end

    walking_one_rr_arbiter #(.NUM_CH(4), .DATA_WIDTH(32), .MAX_HOLD(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Request(req0), .DataIn(data_in),
        .Grant(g0), .GrantIndex(gi0), .GrantValid(gv0), .DataOut(do0), .HoldExpired(he0));

    walking_one_rr_arbiter #(.NUM_CH(4), .DATA_WIDTH(32), .MAX_HOLD(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Request(req2), .DataIn(data_in),
        .Grant(g2), .GrantIndex(gi2), .GrantValid(gv2), .DataOut(do2), .HoldExpired(he2));

    walking_one_rr_arbiter #(.NUM_CH(4), .DATA_WIDTH(32), .MAX_HOLD(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Request(req3), .DataIn(data_in),
        .Grant(g3), .GrantIndex(gi3), .GrantValid(gv3), .DataOut(do3), .HoldExpired(he3));

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) din[i] = $urandom;
    endtask

    task automatic do_reset();
        Reset  = 1'b0;
        Enable = 1'b1;
        req0 = 4'b0; req2 = 4'b0; req3 = 4'b0;
        randomize_data();
        step();
        step();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (g0 !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected %b", g0, 4'b0000); end
        checks++; if (gi0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_index: got %0d expected 0", gi0); end
        checks++; if (gv0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", gv0); end
        checks++; if (do0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", do0); end
        checks++; if (he0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_expired: got %b expected 0", he0); end
        checks++; if (dut0.ptr !== 4'b0001) begin errors++; $display("[TB] FAIL reset_ptr: got %b expected 0001", dut0.ptr); end
    endtask

    task automatic test_basic_grant();
        logic [31:0] exp_d;
        do_reset();
        req0 = 4'b1010;
        randomize_data();
        exp_d = din[1];
        step();
        checks++; if (g0 !== 4'b0010) begin errors++; $display("[TB] FAIL basic_grant: got %b expected 0010", g0); end
        checks++; if (gi0 !== 2'd1) begin errors++; $display("[TB] FAIL basic_index: got %0d expected 1", gi0); end
        checks++; if (gv0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", gv0); end
        checks++; if (do0 !== exp_d) begin errors++; $display("[TB] FAIL basic_data: got %h expected %h", do0, exp_d); end
        req0 = 4'b1000;
        randomize_data();
        exp_d = din[3];
        step();
        checks++; if (g0 !== 4'b1000) begin errors++; $display("[TB] FAIL release_grant: got %b expected 1000", g0); end
        checks++; if (gi0 !== 2'd3) begin errors++; $display("[TB] FAIL release_index: got %0d expected 3", gi0); end
        checks++; if (do0 !== exp_d) begin errors++; $display("[TB] FAIL release_data: got %h expected %h", do0, exp_d); end
        checks++; if (dut0.ptr !== 4'b0100) begin errors++; $display("[TB] FAIL release_ptr: got %b expected 0100", dut0.ptr); end
        randomize_data();
        exp_d = din[3];
        step();
        checks++; if (do0 !== exp_d) begin errors++; $display("[TB] FAIL hold_data_update: got %h expected %h", do0, exp_d); end
        req0 = 4'b0000;
        step();
        checks++; if (g0 !== 4'b0000 || gv0 !== 1'b0 || do0 !== 32'h0) begin
            errors++; $display("[TB] FAIL to_idle: got grant %b valid %b data %h expected 0000 0 0", g0, gv0, do0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_g;
        logic [31:0] exp_d;
        int          ch;
        do_reset();
        req0 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ch    = k % 4;
            exp_g = 4'b0001 << ch;
            randomize_data();
            exp_d = din[ch];
            step();
            checks++; if (g0 !== exp_g || gv0 !== 1'b1) begin
                errors++; $display("[TB] FAIL rr_order_%0d: got %b valid %b expected %b valid 1", k, g0, gv0, exp_g);
            end
            checks++; if (do0 !== exp_d) begin errors++; $display("[TB] FAIL rr_data_%0d: got %h expected %h", k, do0, exp_d); end
            req0 = 4'b1111;
            step();
            checks++; if (g0 !== exp_g) begin errors++; $display("[TB] FAIL rr_hold_%0d: got %b expected %b", k, g0, exp_g); end
            req0 = 4'b1111 & ~exp_g;
        end
    endtask

    task automatic test_max_hold();
        logic [3:0] exp_g [7];
        logic       exp_he [7];
        exp_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        exp_he = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        req3 = 4'b0011;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++; if (g3 !== exp_g[c] || he3 !== exp_he[c]) begin
                errors++; $display("[TB] FAIL max_hold_cycle_%0d: got grant %b expired %b expected %b %b", c, g3, he3, exp_g[c], exp_he[c]);
            end
        end
    endtask

    task automatic test_sole_requester();
        logic exp_he [6];
        exp_he = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        req2 = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (g2 !== 4'b0100 || gv2 !== 1'b1 || he2 !== exp_he[c]) begin
                errors++; $display("[TB] FAIL sole_cycle_%0d: got grant %b valid %b expired %b expected 0100 1 %b", c, g2, gv2, he2, exp_he[c]);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [3:0]  scramble [5];
        logic [31:0] exp_d;
        scramble = '{4'b0010, 4'b1100, 4'b0000, 4'b1111, 4'b0110};
        do_reset();
        req3 = 4'b0011;
        step();
        randomize_data();
        exp_d = din[0];
        step();
        Enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req3 = scramble[c];
            randomize_data();
            step();
            checks++; if (g3 !== 4'b0001 || gi3 !== 2'd0 || gv3 !== 1'b1 || he3 !== 1'b0 || do3 !== exp_d) begin
                errors++; $display("[TB] FAIL freeze_%0d: got grant %b idx %0d valid %b expired %b data %h expected 0001 0 1 0 %h",
                                   c, g3, gi3, gv3, he3, do3, exp_d);
            end
        end
        Enable = 1'b1;
        req3 = 4'b0011;
        randomize_data();
        exp_d = din[0];
        step();
        checks++; if (g3 !== 4'b0001 || he3 !== 1'b0 || do3 !== exp_d) begin
            errors++; $display("[TB] FAIL resume_keep: got grant %b expired %b data %h expected 0001 0 %h", g3, he3, do3, exp_d);
        end
        step();
        checks++; if (g3 !== 4'b0010 || he3 !== 1'b1) begin
            errors++; $display("[TB] FAIL resume_expire: got grant %b expired %b expected 0010 1", g3, he3);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req0 = 4'b1000;
        step();
        req0 = 4'b1111;
        step();
        checks++; if (g0 !== 4'b1000) begin errors++; $display("[TB] FAIL midreset_setup: got %b expected 1000", g0); end
        Reset  = 1'b0;
        Enable = 1'b0;
        step();
        checks++; if (g0 !== 4'b0000 || gi0 !== 2'd0 || gv0 !== 1'b0 || do0 !== 32'h0 || he0 !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_clear: got grant %b idx %0d valid %b data %h expired %b expected all 0",
                               g0, gi0, gv0, do0, he0);
        end
        Enable = 1'b1;
        Reset  = 1'b1;
        step();
        checks++; if (g0 !== 4'b0001 || gi0 !== 2'd0) begin
            errors++; $display("[TB] FAIL midreset_regrant: got grant %b idx %0d expected 0001 0", g0, gi0);
        end
    endtask

    task automatic test_random_onehot();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req0   = 4'($urandom);
            req2   = 4'($urandom);
            req3   = 4'($urandom);
            Enable = ($urandom_range(0, 7) != 0);
            randomize_data();
            step();
            checks++; if (!$onehot0(g0) || !$onehot0(g2) || !$onehot0(g3)) begin
                errors++; $display("[TB] FAIL onehot_%0d: got %b %b %b expected one-hot or zero", c, g0, g2, g3);
            end
            checks++; if (gv0 !== |g0 || gv2 !== |g2 || gv3 !== |g3) begin
                errors++; $display("[TB] FAIL valid_match_%0d: got valid %b%b%b expected %b%b%b", c, gv0, gv2, gv3, |g0, |g2, |g3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_back_to_back();
        test_max_hold();
        test_sole_requester();
        test_enable_freeze();
        test_reset_mid_grant();
        test_random_onehot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
